pe_max_sched: RTL and testbench
===============================

# pe_max_sched

Window sequencer for the `pe_max` max-pooling datapath. It accepts a stream of `DATA_COPIES`-lane activation vectors and groups them into pooling windows of a configured length. It drives the `pe_max` enable, clear and valid controls, captures one max vector per window into an output register, and hands it downstream over a valid/ready handshake. It sits between the feature-map read path and the pooling write-back path.

## Interface
- `DATA_WIDTH`, 8, lane width in bits (signed).
- `DATA_COPIES`, 32, lanes per vector.
- `LEN_W`, 8, width of the window-length field.
- `NUM_W`, 16, width of the window-count field.

Clock and reset: one clock; reset is synchronous and active-high. The ports are `i_clk` and `i_rst`.

- `i_clk`  in  1  clock.
- `i_rst`  in  1  synchronous active-high reset.
- `i_start`  in  1  job start pulse; sampled only in IDLE.
- `i_abort`  in  1  synchronous job abort; any state.
- `i_cfg_win_len`  in  LEN_W  beats per window; latched on start.
- `i_cfg_win_num`  in  NUM_W  windows per job; latched on start.
- `o_busy`  out  1  high whenever state != IDLE.
- `o_done`  out  1  one-cycle pulse at job completion.
- `i_in_data`  in  DC*DW  input vector.
- `i_in_vld`  in  1  input valid.
- `o_in_rdy`  out  1  input ready.
- `o_mdata`  out  DC*DW  to `pe_max` `i_mdata`; equals `i_in_data` (combinational).
- `o_mdata_vld`  out  1  to `pe_max` `i_mdata_vld`.
- `o_max_en`  out  1  to `pe_max` `i_max_en`.
- `o_max_clear`  out  1  to `pe_max` `i_max_clear`.
- `i_max_result`  in  2*DC*DW  from `pe_max` `o_max_result`; only bits [DC*DW-1:0] are used.
- `o_out_data`  out  DC*DW  registered window max.
- `o_out_vld`  out  1  output valid.
- `i_out_rdy`  in  1  output ready.
- `o_out_last`  out  1  qualifies the final window of the job.

## Operation
- **States:** IDLE, RUN, DRAIN.
- **IDLE:**
  - `i_start` with both cfg values nonzero: latch cfg, clear `beat_cnt` and `win_cnt`, go to RUN.
  - `i_start` with either cfg value zero: stay in IDLE and pulse `o_done` next cycle.
- **Beat accepted:** `acc = i_in_vld & o_in_rdy`. `o_mdata_vld = acc`.
- **Enable:** `o_max_en = (state==RUN)`. A low enable holds `pe_max` cleared (0x80 per lane) outside RUN.
- **Last beat:** `last_beat = (beat_cnt == len-1)`. On `acc & last_beat`:
  - `o_max_clear` = 1 in that cycle (combinational).
  - `o_out_data` <= `i_max_result[DC*DW-1:0]`, which includes the current beat.
  - `o_out_vld` <= 1.
  - `o_out_last` <= (`win_cnt == num-1`).
  - `beat_cnt` <= 0 and `win_cnt` increments.
  - If it is the last window, go to DRAIN.
- **Any other accepted beat:** `beat_cnt` increments.
- **Ready:** `o_in_rdy = RUN & (!last_beat | !o_out_vld | i_out_rdy)`. Only a window's final beat is stalled, and only by a full, non-draining output register.
- **Output register:**
  - Cleared by `o_out_vld & i_out_rdy` unless it is reloaded in the same cycle; a reload takes priority.
  - `o_out_data` holds its value while `o_out_vld & !i_out_rdy`.
- **DRAIN:** on output handshake go to IDLE; `o_done` = 1 in the following cycle.
- **Abort:** `i_abort` has priority over `i_start` and all other events.
  - Next cycle: state = IDLE, `o_out_vld` = 0, `o_out_last` = 0, counters = 0, no `o_done`.
  - `o_max_en` drops, which clears `pe_max`.
- **Arithmetic:**
  - Counters are unsigned and never wrap.
  - `len = 1` makes every beat a last beat.
  - Maxima are signed per lane, as computed by `pe_max`; this block does not inspect data.

## Timing
- **Reset values:** all outputs 0: `o_busy`, `o_done`, `o_in_rdy`, `o_mdata_vld`, `o_max_en`, `o_max_clear`, `o_out_vld`, `o_out_last`, `o_out_data`. State = IDLE.
- **Start:** `i_start` at cycle T gives `o_busy`, `o_max_en` and `o_in_rdy` high at T+1.
- **Window latency:** the last beat accepted at cycle T gives `o_out_vld` at T+1.
- **Throughput:** with `i_out_rdy` held high, the next window's first beat is accepted at T+1 with no bubble. Throughput is one beat per cycle.
- **Completion:** the final output handshake at cycle T gives IDLE at T+1 and `o_done` high for T+1 only.
- **Reset mid-job:** `i_rst` during RUN or DRAIN gives reset values next cycle; any partial window is discarded.

## Test plan
- **Single 2x2 window:** len=4, num=1, lane0 beats 3,-7,12,5 and all other lanes -1 → one output with lane0=12 and others=-1. `o_out_last`=1. `o_done` pulses one cycle after the handshake.
- **Back-to-back windows:** len=2, num=3, continuous input, `i_out_rdy`=1 → three outputs on consecutive windows with no input bubble. Each window's max is independent (no carry-over); check this with a descending-value second window.
- **Backpressure:** len=2, num=2, `i_out_rdy`=0 for 5 cycles → `o_in_rdy` is low only on window 2's final beat. `o_out_data` is stable while stalled. Both results are correct after release.
- **len=1:** len=1, num=4 → each output equals its input vector, and `o_max_clear` is high every accepted beat.
- **Zero config:** num=0 → no RUN, `o_done` one cycle after start, `o_out_vld` never asserts.
- **Abort and reset:** `i_abort` after beat 2 of len=4 → IDLE next cycle with no output and no `o_done`. A new job then returns correct maxima with no stale value. Repeat the same sequence with `i_rst`.

Source files
------------

// File: rtl/pe_max_sched.sv
// Window sequencer for the pe_max pooling datapath: groups input beats into windows,
// steers pe_max enable/clear, and registers one max vector per window for downstream.
module pe_max_sched #(
  parameter int DATA_WIDTH  = 8,
  parameter int DATA_COPIES = 32,
  parameter int LEN_W       = 8,
  parameter int NUM_W       = 16
) (
  input  logic                              i_clk,
  input  logic                              i_rst,
  input  logic                              i_start,
  input  logic                              i_abort,
  input  logic [LEN_W-1:0]                  i_cfg_win_len,
  input  logic [NUM_W-1:0]                  i_cfg_win_num,
  output logic                              o_busy,
  output logic                              o_done,
  input  logic [DATA_COPIES*DATA_WIDTH-1:0] i_in_data,
  input  logic                              i_in_vld,
  output logic                              o_in_rdy,
  output logic [DATA_COPIES*DATA_WIDTH-1:0] o_mdata,
  output logic                              o_mdata_vld,
  output logic                              o_max_en,
  output logic                              o_max_clear,
  input  logic [2*DATA_COPIES*DATA_WIDTH-1:0] i_max_result,
  output logic [DATA_COPIES*DATA_WIDTH-1:0] o_out_data,
  output logic                              o_out_vld,
  input  logic                              i_out_rdy,
  output logic                              o_out_last
);

  // state   | meaning
  // S_IDLE  | waiting for i_start; pe_max held cleared
  // S_RUN   | accepting beats, emitting one max per window
  // S_DRAIN | final window registered, waiting for its handshake
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  localparam int VW = DATA_COPIES * DATA_WIDTH;

  state_t           state, state_nxt;
  logic [LEN_W-1:0] len_q, beat_cnt;
  logic [NUM_W-1:0] num_q, win_cnt;
  logic             cfg_ok, last_beat, last_win, acc, win_end, out_hs, done_nxt;
  logic             max_hi_unused;

  // pe_max exposes a double-width result; only the low half carries the lane maxima.
  assign max_hi_unused = ^i_max_result[2*VW-1:VW];

  assign cfg_ok    = (i_cfg_win_len != '0) && (i_cfg_win_num != '0);
  assign last_beat = (beat_cnt == len_q - LEN_W'(1));
  assign last_win  = (win_cnt == num_q - NUM_W'(1));
  assign out_hs    = o_out_vld && i_out_rdy;
  assign o_mdata   = i_in_data;

  always_comb begin
    state_nxt   = state;
    done_nxt    = 1'b0;
    o_busy      = (state != S_IDLE);
    o_max_en    = (state == S_RUN);
    o_in_rdy    = (state == S_RUN) && (!last_beat || !o_out_vld || i_out_rdy);
    acc         = i_in_vld && o_in_rdy;
    win_end     = acc && last_beat;
    o_mdata_vld = acc;
    o_max_clear = win_end;
    case (state)
      S_IDLE: begin
        if (i_start) begin
          if (cfg_ok) state_nxt = S_RUN;
          else        done_nxt  = 1'b1;
        end
      end
      S_RUN:   if (win_end && last_win) state_nxt = S_DRAIN;
      S_DRAIN: begin
        if (out_hs) begin
          state_nxt = S_IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
    if (i_abort) begin
      state_nxt = S_IDLE;
      done_nxt  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state  <= S_IDLE;
      o_done <= 1'b0;
    end else begin
      state  <= state_nxt;
      o_done <= done_nxt;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      len_q      <= '0;
      num_q      <= '0;
      beat_cnt   <= '0;
      win_cnt    <= '0;
      o_out_data <= '0;
      o_out_vld  <= 1'b0;
      o_out_last <= 1'b0;
    end else if (i_abort) begin
      beat_cnt   <= '0;
      win_cnt    <= '0;
      o_out_vld  <= 1'b0;
      o_out_last <= 1'b0;
    end else begin
      if (state == S_IDLE && i_start && cfg_ok) begin
        len_q    <= i_cfg_win_len;
        num_q    <= i_cfg_win_num;
        beat_cnt <= '0;
        win_cnt  <= '0;
      end
      if (acc) begin
        if (last_beat) begin
          beat_cnt <= '0;
          win_cnt  <= win_cnt + NUM_W'(1);
        end else begin
          beat_cnt <= beat_cnt + LEN_W'(1);
        end
      end
      // A reload on a window's final beat wins over draining the previous result.
      if (win_end) begin
        o_out_data <= i_max_result[VW-1:0];
        o_out_vld  <= 1'b1;
        o_out_last <= last_win;
      end else if (out_hs) begin
        o_out_vld  <= 1'b0;
        o_out_last <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pe_max_sched.sv
// Self-checking bench for pe_max_sched: a stand-in pe_max plus a transaction-level
// model that rebuilds each window's maximum from the list of accepted beats.
module tb_pe_max_sched;
  localparam int DW = 8;
  localparam int DC = 32;
  localparam int VW = DW * DC;
  localparam int LW = 8;
  localparam int NW = 16;

  logic            i_clk = 1'b0;
  logic            i_rst = 1'b1;
  logic            i_start = 1'b0;
  logic            i_abort = 1'b0;
  logic [LW-1:0]   i_cfg_win_len = '0;
  logic [NW-1:0]   i_cfg_win_num = '0;
  logic            o_busy, o_done;
  logic [VW-1:0]   i_in_data = '0;
  logic            i_in_vld = 1'b0;
  logic            o_in_rdy;
  logic [VW-1:0]   o_mdata;
  logic            o_mdata_vld, o_max_en, o_max_clear;
  logic [2*VW-1:0] i_max_result;
  logic [VW-1:0]   o_out_data;
  logic            o_out_vld;
  logic            i_out_rdy = 1'b0;
  logic            o_out_last;

  always #5 i_clk = ~i_clk;

  pe_max_sched dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_abort(i_abort),
    .i_cfg_win_len(i_cfg_win_len), .i_cfg_win_num(i_cfg_win_num),
    .o_busy(o_busy), .o_done(o_done),
    .i_in_data(i_in_data), .i_in_vld(i_in_vld), .o_in_rdy(o_in_rdy),
    .o_mdata(o_mdata), .o_mdata_vld(o_mdata_vld), .o_max_en(o_max_en),
    .o_max_clear(o_max_clear), .i_max_result(i_max_result),
    .o_out_data(o_out_data), .o_out_vld(o_out_vld), .i_out_rdy(i_out_rdy),
    .o_out_last(o_out_last)
  );

  // Stand-in pe_max: running signed max per lane, result includes the current beat.
  logic [VW-1:0] pm_acc, pm_res;
  logic [VW-1:0] pm_junk = '0;
  always_comb begin
    pm_res = pm_acc;
    for (int l = 0; l < DC; l++) begin
      if (!o_max_en) pm_res[l*DW +: DW] = 8'h80;
      else if (o_mdata_vld && ($signed(o_mdata[l*DW +: DW]) > $signed(pm_acc[l*DW +: DW])))
        pm_res[l*DW +: DW] = o_mdata[l*DW +: DW];
    end
  end
  assign i_max_result = {pm_junk, pm_res};
  always_ff @(posedge i_clk) begin
    if (!o_max_en || o_max_clear) pm_acc <= {DC{8'h80}};
    else if (o_mdata_vld)         pm_acc <= pm_res;
  end

  int            checks = 0;
  int            failures = 0;
  int            m_state = 0;
  int            m_len = 0, m_num = 0, m_win = 0;
  logic          m_known = 1'b0;
  logic          m_ovld = 1'b0, m_olast = 1'b0, m_done = 1'b0;
  logic [VW-1:0] m_odata = '0;
  logic [VW-1:0] m_beats[$];
  logic [VW-1:0] got_q[$];
  int            tb_len = 0, tb_num = 0;

  task automatic chk(input string tag, input logic [VW-1:0] obs, input logic [VW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [VW-1:0] rand_vec();
    logic [VW-1:0] v;
    for (int i = 0; i < VW/32; i++) v[i*32 +: 32] = $urandom;
    return v;
  endfunction

  function automatic logic [VW-1:0] window_max();
    logic [VW-1:0] r;
    int best, v;
    r = '0;
    for (int l = 0; l < DC; l++) begin
      best = -128;
      foreach (m_beats[b]) begin
        v = $signed(m_beats[b][l*DW +: DW]);
        if (v > best) best = v;
      end
      r[l*DW +: DW] = best[DW-1:0];
    end
    return r;
  endfunction

  task automatic step(input logic vld, input logic [VW-1:0] data, input logic ordy,
                      input logic start, input logic abort, input logic rst);
    logic e_en, e_last, e_rdy, e_acc, hs, ndone;
    @(negedge i_clk);
    i_in_vld = vld; i_in_data = data; i_out_rdy = ordy;
    i_start = start; i_abort = abort; i_rst = rst;
    i_cfg_win_len = tb_len[LW-1:0]; i_cfg_win_num = tb_num[NW-1:0];
    pm_junk = rand_vec();
    #1;
    e_en   = (m_state == 1);
    e_last = (m_beats.size() == m_len - 1);
    e_rdy  = e_en && (!e_last || !m_ovld || ordy);
    e_acc  = vld && e_rdy;
    hs     = m_ovld && ordy;
    if (m_known) begin
      chk("busy", o_busy, m_state != 0);
      chk("max_en", o_max_en, e_en);
      chk("in_rdy", o_in_rdy, e_rdy);
      chk("mdata_vld", o_mdata_vld, e_acc);
      chk("max_clear", o_max_clear, e_acc && e_last);
      chk("mdata", o_mdata, data);
      chk("out_vld", o_out_vld, m_ovld);
      chk("out_last", o_out_last, m_olast);
      chk("out_data", o_out_data, m_odata);
      chk("done", o_done, m_done);
      if (o_out_vld === 1'b1 && ordy) got_q.push_back(o_out_data);
    end
    ndone = 1'b0;
    if (rst) begin
      m_state = 0; m_ovld = 0; m_olast = 0; m_odata = '0; m_done = 0;
      m_beats.delete(); m_win = 0; m_known = 1'b1;
    end else if (abort) begin
      m_state = 0; m_ovld = 0; m_olast = 0; m_done = 0;
      m_beats.delete(); m_win = 0;
    end else begin
      if (m_state == 0 && start) begin
        if (tb_len != 0 && tb_num != 0) begin
          m_state = 1; m_len = tb_len; m_num = tb_num; m_win = 0; m_beats.delete();
        end else ndone = 1'b1;
      end
      if (e_acc) m_beats.push_back(data);
      if (e_acc && e_last) begin
        m_odata = window_max();
        m_ovld  = 1'b1;
        m_olast = (m_win == m_num - 1);
        m_beats.delete();
        m_win++;
        if (m_olast) m_state = 2;
      end else if (hs) begin
        m_ovld = 1'b0; m_olast = 1'b0;
        if (m_state == 2) begin
          m_state = 0;
          ndone = 1'b1;
        end
      end
      m_done = ndone;
    end
  endtask

  task automatic finish_job(input int vld_pct, input int rdy_pct);
    int n;
    n = 0;
    while (m_state != 0 && n < 3000) begin
      step($urandom_range(99) < vld_pct, rand_vec(), $urandom_range(99) < rdy_pct, 0, 0, 0);
      n++;
    end
    chk("job_completes", n < 3000, 1'b1);
    step(0, rand_vec(), 1, 0, 0, 0);
  endtask

  task automatic run_job(input int len, input int num, input int vld_pct, input int rdy_pct);
    tb_len = len; tb_num = num;
    step(0, rand_vec(), 1, 1, 0, 0);
    finish_job(vld_pct, rdy_pct);
  endtask

  function automatic logic [VW-1:0] lane_vec(input logic [7:0] lane0, input logic [7:0] rest);
    logic [VW-1:0] v;
    for (int l = 0; l < DC; l++) v[l*DW +: DW] = rest;
    v[DW-1:0] = lane0;
    return v;
  endfunction

  initial begin
    logic [7:0] t1_beats[4];
    logic [VW-1:0] exp_v;
    t1_beats = '{8'd3, 8'hF9, 8'd12, 8'd5};

    // reset, then reset values are compared by the first non-reset steps
    repeat (3) step(0, '0, 0, 0, 0, 1);
    repeat (2) step(0, '0, 0, 0, 0, 0);

    // single window, lane0 3,-7,12,5 and other lanes -1
    got_q.delete();
    tb_len = 4; tb_num = 1;
    step(0, '0, 1, 1, 0, 0);
    foreach (t1_beats[i]) step(1, lane_vec(t1_beats[i], 8'hFF), 1, 0, 0, 0);
    finish_job(100, 100);
    exp_v = lane_vec(8'd12, 8'hFF);
    chk("t1_count", got_q.size(), 1);
    chk("t1_result", got_q[0], exp_v);

    // back-to-back windows, second window descending and below the first
    got_q.delete();
    tb_len = 2; tb_num = 3;
    step(0, '0, 1, 1, 0, 0);
    step(1, {DC{8'h70}}, 1, 0, 0, 0);
    step(1, {DC{8'h65}}, 1, 0, 0, 0);
    step(1, {DC{8'h60}}, 1, 0, 0, 0);
    step(1, {DC{8'h30}}, 1, 0, 0, 0);
    step(1, {DC{8'h10}}, 1, 0, 0, 0);
    step(1, {DC{8'h20}}, 1, 0, 0, 0);
    finish_job(100, 100);
    chk("t2_count", got_q.size(), 3);
    exp_v = {DC{8'h60}};
    chk("t2_win1", got_q[1], exp_v);
    exp_v = {DC{8'h20}};
    chk("t2_win2", got_q[2], exp_v);

    // backpressure: output not ready for five cycles
    got_q.delete();
    tb_len = 2; tb_num = 2;
    step(0, '0, 0, 1, 0, 0);
    repeat (5) step(1, rand_vec(), 0, 0, 0, 0);
    finish_job(100, 100);
    chk("t3_count", got_q.size(), 2);

    // len = 1
    got_q.delete();
    run_job(1, 4, 70, 100);
    chk("t4_count", got_q.size(), 4);

    // zero configuration
    got_q.delete();
    tb_len = 3; tb_num = 0;
    step(0, '0, 1, 1, 0, 0);
    repeat (3) step(1, rand_vec(), 1, 0, 0, 0);
    tb_len = 0; tb_num = 2;
    step(0, '0, 1, 1, 0, 0);
    repeat (3) step(1, rand_vec(), 1, 0, 0, 0);
    chk("t5_count", got_q.size(), 0);

    // abort after two beats, then a fresh job
    got_q.delete();
    tb_len = 4; tb_num = 2;
    step(0, '0, 1, 1, 0, 0);
    step(1, {DC{8'h7F}}, 1, 0, 0, 0);
    step(1, {DC{8'h7E}}, 1, 0, 0, 0);
    step(1, rand_vec(), 1, 0, 1, 0);
    repeat (2) step(1, rand_vec(), 1, 0, 0, 0);
    chk("t6_discarded", got_q.size(), 0);
    run_job(3, 2, 80, 100);
    chk("t6_count", got_q.size(), 2);

    // same with reset
    got_q.delete();
    tb_len = 4; tb_num = 2;
    step(0, '0, 1, 1, 0, 0);
    step(1, {DC{8'h7F}}, 1, 0, 0, 0);
    step(1, {DC{8'h7E}}, 1, 0, 0, 0);
    step(1, rand_vec(), 1, 0, 0, 1);
    repeat (2) step(1, rand_vec(), 1, 0, 0, 0);
    chk("t7_discarded", got_q.size(), 0);
    run_job(3, 2, 80, 100);
    chk("t7_count", got_q.size(), 2);

    // randomized jobs with random valid and ready
    for (int j = 0; j < 8; j++) run_job($urandom_range(5, 1), $urandom_range(3, 1), 75, 60);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
